mvu_bs: RTL and testbench

- Bit-serial, precision-configurable matrix-vector unit: next generation of the fixed 2-bit MVU.
- Owns its own sequencer. For each weight bit-plane i and data bit-plane j it fetches the planes from external bit-plane memories, forms per-row AND-popcounts, then shifts, signs and accumulates them into N accumulators.
- Supports 1..PMAX-bit signed/unsigned operands, start/done handshake, and accumulate-across-jobs (K-tiling).

---
 rtl/mvu_bs_pkg.sv | 29 ++
 rtl/mvu_bs_lane.sv | 59 +++++
 rtl/mvu_bs.sv | 173 +++++++++++++++++
 tb/tb_mvu_bs.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_bs_pkg.sv
// Shared types and helpers for the bit-serial matrix-vector unit.
// Holds the sequencer state encoding, the derived widths and the precision clamp.
package mvu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int unsigned addr_width(input int unsigned pmax);
        return $clog2(pmax);
    endfunction

    function automatic int unsigned prec_width(input int unsigned pmax);
        return $clog2(pmax + 1);
    endfunction

    function automatic int unsigned pc_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Zero or out-of-range precision requests run at full precision.
    function automatic int unsigned clamp_prec(input int unsigned p, input int unsigned pmax);
        return (p == 0 || p > pmax) ? pmax : p;
    endfunction

endpackage

// File: rtl/mvu_bs_lane.sv
// One row of the matrix-vector unit: AND-popcount register, then a shifted,
// optionally negated term added into a wrapping W-bit accumulator.
module mvu_bs_lane
    import mvu_pkg::*;
#(
    parameter int N  = 64,
    parameter int W  = 32,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clr,
    input  logic          pc_en,
    input  logic          acc_en,
    input  logic [SW-1:0] sh,
    input  logic          neg,
    input  logic [N-1:0]  w_row,
    input  logic [N-1:0]  d_vec,
    output logic [W-1:0]  acc
);

    localparam int PCW = pc_width(N);

    logic [PCW-1:0] pc_nx;
    logic [PCW-1:0] pc_r;
    logic [W-1:0]   term;
    logic [W-1:0]   addend;

    always_comb begin
        pc_nx = '0;
        for (int unsigned b = 0; b < N; b++) begin
            pc_nx = pc_nx + PCW'(w_row[b] & d_vec[b]);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_r <= '0;
        end else if (pc_en) begin
            pc_r <= pc_nx;
        end
    end

    always_comb begin
        term   = W'(pc_r) << sh;
        addend = neg ? (~term + W'(1)) : term;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/mvu_bs.sv
// Bit-serial, precision-configurable matrix-vector unit with its own sequencer.
// Walks weight/data bit-plane pairs (i outer, j inner) through a 3-stage pipeline into N lanes.
module mvu_bs
    import mvu_pkg::*;
#(
    parameter int N    = 64,
    parameter int W    = 32,
    parameter int PMAX = 8,
    parameter int PA   = addr_width(PMAX),
    parameter int PB   = prec_width(PMAX)
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           start,
    input  logic           keep,
    input  logic [1:0]     mode,
    input  logic [PB-1:0]  wprec,
    input  logic [PB-1:0]  dprec,
    output logic           busy,
    output logic           done,
    output logic [PA-1:0]  w_addr,
    output logic           w_rd,
    input  logic [N*N-1:0] w_data,
    output logic [PA-1:0]  d_addr,
    output logic           d_rd,
    input  logic [N-1:0]   d_data,
    output logic [N*W-1:0] O
);

    localparam int SW = PA + 1;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    mode_r;
    logic [PB-1:0] wp_r;
    logic [PB-1:0] dp_r;
    logic [PB-1:0] wp_in;
    logic [PB-1:0] dp_in;
    logic [PA-1:0] i_cnt;
    logic [PA-1:0] j_cnt;
    logic          i_last;
    logic          j_last;
    logic          accept;
    logic          issue;
    logic          clr_acc;

    logic          v1;
    logic          v2;
    logic [PA-1:0] i1;
    logic [PA-1:0] j1;
    logic          neg1;
    logic          neg2;
    logic [SW-1:0] sh2;

    assign wp_in   = PB'(clamp_prec(32'(wprec), PMAX));
    assign dp_in   = PB'(clamp_prec(32'(dprec), PMAX));
    assign i_last  = (PB'(i_cnt) == wp_r - PB'(1));
    assign j_last  = (PB'(j_cnt) == dp_r - PB'(1));
    assign clr_acc = accept && !keep;
    assign w_addr  = i_cnt;
    assign d_addr  = j_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        issue    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        w_rd     = 1'b0;
        d_rd     = 1'b0;
        case (state)
            S_IDLE: begin
                busy   = 1'b0;
                accept = start;
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                issue = 1'b1;
                w_rd  = 1'b1;
                d_rd  = 1'b1;
                if (i_last && j_last) state_nx = S_DRAIN;
            end
            // Once the last pair has left the memory stage, its term lands on the next edge.
            S_DRAIN: begin
                if (!v1) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Plane counters stop on the final pair so the addresses hold while idle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mode_r <= '0;
            wp_r   <= '0;
            dp_r   <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
        end else if (accept) begin
            mode_r <= mode;
            wp_r   <= wp_in;
            dp_r   <= dp_in;
            i_cnt  <= '0;
            j_cnt  <= '0;
        end else if (issue && !(i_last && j_last)) begin
            if (j_last) begin
                j_cnt <= '0;
                i_cnt <= i_cnt + PA'(1);
            end else begin
                j_cnt <= j_cnt + PA'(1);
            end
        end
    end

    assign neg1 = (mode_r[0] && (PB'(i1) == wp_r - PB'(1)))
                ^ (mode_r[1] && (PB'(j1) == dp_r - PB'(1)));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            i1   <= '0;
            j1   <= '0;
            sh2  <= '0;
            neg2 <= 1'b0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            if (issue) begin
                i1 <= i_cnt;
                j1 <= j_cnt;
            end
            if (v1) begin
                sh2  <= SW'(i1) + SW'(j1);
                neg2 <= neg1;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        mvu_bs_lane #(
            .N  (N),
            .W  (W),
            .SW (SW)
        ) u_lane (
            .clk    (clk),
            .clr_n  (clr_n),
            .clr    (clr_acc),
            .pc_en  (v1),
            .acc_en (v2),
            .sh     (sh2),
            .neg    (neg2),
            .w_row  (w_data[r*N +: N]),
            .d_vec  (d_data),
            .acc    (O[r*W +: W])
        );
    end

endmodule

// File: tb/tb_mvu_bs.sv
// Directed bench for mvu_bs: hand-computed results, issue order, latency and reset behaviour.
// Bit-plane memories are modelled with one-cycle read latency and junk data when not read.
module tb_mvu_bs;

    localparam int N    = 64;
    localparam int W    = 32;
    localparam int PMAX = 8;
    localparam int PA   = 3;
    localparam int PB   = 4;

    logic           clk;
    logic           clr_n;
    logic           start;
    logic           keep;
    logic [1:0]     mode;
    logic [PB-1:0]  wprec;
    logic [PB-1:0]  dprec;
    logic           busy;
    logic           done;
    logic [PA-1:0]  w_addr;
    logic           w_rd;
    logic [N*N-1:0] w_data;
    logic [PA-1:0]  d_addr;
    logic           d_rd;
    logic [N-1:0]   d_data;
    logic [N*W-1:0] O;

    logic [N*N-1:0] wmem [PMAX];
    logic [N-1:0]   dmem [PMAX];

    int nchk;
    int nerr;
    int nlog;
    int lw [64];
    int ld [64];

    mvu_bs #(
        .N    (N),
        .W    (W),
        .PMAX (PMAX),
        .PA   (PA),
        .PB   (PB)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .keep   (keep),
        .mode   (mode),
        .wprec  (wprec),
        .dprec  (dprec),
        .busy   (busy),
        .done   (done),
        .w_addr (w_addr),
        .w_rd   (w_rd),
        .w_data (w_data),
        .d_addr (d_addr),
        .d_rd   (d_rd),
        .d_data (d_data),
        .O      (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data <= w_rd ? wmem[w_addr] : '1;
        d_data <= d_rd ? dmem[d_addr] : '1;
    end

    always @(negedge clk) begin
        if (w_rd && nlog < 64) begin
            lw[nlog] = int'(w_addr);
            ld[nlog] = int'(d_addr);
            nlog++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rows(input string tag, input logic [W-1:0] exp0, input logic [W-1:0] exp_rest);
        for (int r = 0; r < N; r++) begin
            check($sformatf("%s_row%0d", tag, r), 64'(O[r*W +: W]), 64'(r == 0 ? exp0 : exp_rest));
        end
    endtask

    task automatic start_job(input logic k, input logic [1:0] m, input logic [PB-1:0] wp,
                             input logic [PB-1:0] dp);
        @(negedge clk);
        nlog  = 0;
        start = 1'b1;
        keep  = k;
        mode  = m;
        wprec = wp;
        dprec = dp;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int exp_n, input string tag);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 500) begin
            @(posedge clk);
            n++;
            #1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_n));
    endtask

    task automatic finish_job(input string tag);
        check({tag, "_busy_at_done"}, 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, 64'(done), 64'(0));
        check({tag, "_busy_fall"}, 64'(busy), 64'(0));
    endtask

    task automatic load_ones_1x1();
        wmem[0] = '1;
        dmem[0] = '1;
    endtask

    initial begin
        int exp_w [6];
        int exp_d [6];
        exp_w = '{0, 0, 0, 1, 1, 1};
        exp_d = '{0, 1, 2, 0, 1, 2};
        nchk  = 0;
        nerr  = 0;
        nlog  = 0;
        start = 1'b0;
        keep  = 1'b0;
        mode  = 2'b00;
        wprec = '0;
        dprec = '0;
        for (int p = 0; p < PMAX; p++) begin
            wmem[p] = '0;
            dmem[p] = '0;
        end

        clr_n = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_w_rd", 64'(w_rd), 64'(0));
        check("rst_d_rd", 64'(d_rd), 64'(0));
        check("rst_w_addr", 64'(w_addr), 64'(0));
        check("rst_d_addr", 64'(d_addr), 64'(0));
        check("rst_O_row0", 64'(O[0 +: W]), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        // Unsigned 1x1: every row 64, done after E3, a single (0,0) issue.
        load_ones_1x1();
        start_job(1'b0, 2'b00, 4'd1, 4'd1);
        wait_done(0, 3, "u1x1");
        check_rows("u1x1", 32'd64, 32'd64);
        check("u1x1_issues", 64'(nlog), 64'(1));
        check("u1x1_issue_w", 64'(lw[0]), 64'(0));
        check("u1x1_issue_d", 64'(ld[0]), 64'(0));
        finish_job("u1x1");

        // Accumulate onto the previous result, then clear again.
        start_job(1'b1, 2'b00, 4'd1, 4'd1);
        wait_done(0, 3, "keep1");
        check_rows("keep1", 32'd128, 32'd128);
        finish_job("keep1");
        start_job(1'b0, 2'b00, 4'd1, 4'd1);
        wait_done(0, 3, "keep0");
        check_rows("keep0", 32'd64, 32'd64);
        finish_job("keep0");

        // Signed 2x2: weights -1, data +1, junk on idle read cycles must not leak in.
        wmem[0] = '1;
        wmem[1] = '1;
        dmem[0] = '1;
        dmem[1] = '0;
        start_job(1'b0, 2'b11, 4'd2, 4'd2);
        wait_done(0, 6, "s2x2");
        check_rows("s2x2", 32'hFFFF_FFC0, 32'hFFFF_FFC0);
        finish_job("s2x2");

        // 2x3 ordering with a stray start at E4 that must be dropped.
        wmem[0] = '1;
        wmem[1] = '1;
        dmem[0] = '1;
        dmem[1] = '1;
        dmem[2] = '1;
        start_job(1'b0, 2'b00, 4'd2, 4'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4, 8, "o2x3");
        check_rows("o2x3", 32'd1344, 32'd1344);
        check("o2x3_issues", 64'(nlog), 64'(6));
        for (int k = 0; k < 6; k++) begin
            check($sformatf("o2x3_w%0d", k), 64'(lw[k]), 64'(exp_w[k]));
            check($sformatf("o2x3_d%0d", k), 64'(ld[k]), 64'(exp_d[k]));
        end
        finish_job("o2x3");
        check("o2x3_w_addr_hold", 64'(w_addr), 64'(1));
        check("o2x3_d_addr_hold", 64'(d_addr), 64'(2));
        repeat (3) @(posedge clk);
        #1;
        check("o2x3_no_queued_job", 64'(busy), 64'(0));

        // Full precision: single set bit in row 0 / lane 0 on every plane gives 255*255.
        for (int p = 0; p < PMAX; p++) begin
            wmem[p] = '0;
            wmem[p][0] = 1'b1;
            dmem[p] = '0;
            dmem[p][0] = 1'b1;
        end
        start_job(1'b0, 2'b00, 4'd8, 4'd8);
        wait_done(0, 66, "p8x8");
        check_rows("p8x8", 32'd65025, 32'd0);
        finish_job("p8x8");
        start_job(1'b0, 2'b00, 4'd0, 4'd9);
        wait_done(0, 66, "p0x9");
        check_rows("p0x9", 32'd65025, 32'd0);
        check("p0x9_issues", 64'(nlog), 64'(64));
        finish_job("p0x9");

        // Asynchronous reset in the middle of a run, away from any clock edge.
        start_job(1'b1, 2'b00, 4'd8, 4'd8);
        repeat (5) @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_w_rd", 64'(w_rd), 64'(0));
        check("arst_d_rd", 64'(d_rd), 64'(0));
        check("arst_w_addr", 64'(w_addr), 64'(0));
        check("arst_d_addr", 64'(d_addr), 64'(0));
        check("arst_O_row0", 64'(O[0 +: W]), 64'(0));
        @(posedge clk);
        #1;
        check("arst_hold_busy", 64'(busy), 64'(0));
        @(negedge clk);
        clr_n = 1'b1;
        load_ones_1x1();
        start_job(1'b0, 2'b00, 4'd1, 4'd1);
        wait_done(0, 3, "post_rst");
        check_rows("post_rst", 32'd64, 32'd64);
        finish_job("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
